// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level single-master I2C controller.
// Accepts one command per byte (optional START, 8 data bits + ACK, optional STOP)
// and produces open-drain SCL/SDA enables. Every bus phase is four quarters
// (Q0..Q3) of QTR_DIV clk cycles. SCL is released in Q1, where a slave may
// stretch the clock. Outputs are registered copies of the level that the
// upcoming state calls for, so the pins never glitch.
//
// Command handshake: a command transfers on a clk edge where cmd_valid && cmd_ready.
// cmd_ready is high only in IDLE. The host may raise cmd_valid at any time and must
// hold the command fields stable until the transfer. rsp_valid is a single-cycle
// pulse with no back-pressure.
module i2c_byte_master #(
    parameter int QTR_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic       cmd_nack,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe
);

    localparam int CW = $clog2(QTR_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(QTR_DIV - 1);

    // ST_INIT keeps cmd_ready low for the cycle in which reset is still applied.
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_BIT   = 3'd3,
        ST_STOP  = 3'd4
    } state_e;

    state_e        state, stateNext;
    logic [1:0]    qtr, qtrNext;
    logic [CW-1:0] cnt, cntNext;
    logic [3:0]    bitIdx, bitNext;

    // Command fields latched when the command is accepted.
    logic       doStop;
    logic       isRead;
    logic       nackBit;
    logic [7:0] txByte;

    logic [7:0] rxShift;
    logic       ackSample;

    logic       sclOe, sdaOe, busyReg, rspValid, rspNack;
    logic [7:0] rspRdata;
    logic       sclNext, sdaNext;

    logic       effRead, effNack;
    logic [7:0] effByte;
    logic       accept, done, sampleNow;

    // Level of sda_oe for a bit slot: data bits MSB first, then the ACK slot.
    function automatic logic bitLevel(input logic [3:0] idx, input logic rd,
                                      input logic nk, input logic [7:0] b);
        if (idx == 4'd8) begin
            return rd ? ~nk : 1'b0;
        end
        return rd ? 1'b0 : ~b[3'd7 - idx[2:0]];
    endfunction

    assign accept    = cmd_valid && (state == ST_IDLE);
    assign done      = ((state == ST_BIT) || (state == ST_STOP)) && (stateNext == ST_IDLE);
    assign sampleNow = (state == ST_BIT) && (qtr == 2'd2) && (cnt == CNT_LAST);

    // Fields seen by the output logic on the accept cycle come straight from the port.
    assign effRead = (state == ST_IDLE) ? cmd_read  : isRead;
    assign effNack = (state == ST_IDLE) ? cmd_nack  : nackBit;
    assign effByte = (state == ST_IDLE) ? cmd_wdata : txByte;

    // State register: FSM state plus quarter/cycle/bit position.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_INIT;
            qtr    <= 2'd0;
            cnt    <= '0;
            bitIdx <= 4'd0;
        end else begin
            state  <= stateNext;
            qtr    <= qtrNext;
            cnt    <= cntNext;
            bitIdx <= bitNext;
        end
    end

    // Next-state logic: quarter timing, clock stretching in Q1, phase sequencing.
    always_comb begin
        stateNext = state;
        qtrNext   = qtr;
        cntNext   = cnt;
        bitNext   = bitIdx;
        case (state)
            ST_INIT: stateNext = ST_IDLE;
            ST_IDLE: begin
                if (cmd_valid) begin
                    stateNext = (cmd_start || !busyReg) ? ST_START : ST_BIT;
                    qtrNext   = 2'd0;
                    cntNext   = '0;
                    bitNext   = 4'd0;
                end
            end
            default: begin
                // In Q1 the count waits at zero until SCL is actually seen high.
                if (!((qtr == 2'd1) && (cnt == '0) && !scl_in)) begin
                    if (cnt == CNT_LAST) begin
                        cntNext = '0;
                        qtrNext = qtr + 2'd1;
                        if (qtr == 2'd3) begin
                            case (state)
                                ST_START: begin
                                    stateNext = ST_BIT;
                                    bitNext   = 4'd0;
                                end
                                ST_BIT: begin
                                    if (bitIdx == 4'd8) begin
                                        stateNext = doStop ? ST_STOP : ST_IDLE;
                                    end else begin
                                        bitNext = bitIdx + 4'd1;
                                    end
                                end
                                default: stateNext = ST_IDLE;
                            endcase
                        end
                    end else begin
                        cntNext = cnt + CW'(1);
                    end
                end
            end
        endcase
    end

    // Output logic: pin levels for the state/quarter being entered; IDLE holds the bus.
    always_comb begin
        sclNext = sclOe;
        sdaNext = sdaOe;
        case (stateNext)
            ST_START: begin
                case (qtrNext)
                    2'd0:    begin sclNext = busyReg; sdaNext = 1'b0; end
                    2'd1:    begin sclNext = 1'b0;    sdaNext = 1'b0; end
                    2'd2:    begin sclNext = 1'b0;    sdaNext = 1'b1; end
                    default: begin sclNext = 1'b1;    sdaNext = 1'b1; end
                endcase
            end
            ST_BIT: begin
                sclNext = (qtrNext == 2'd0) || (qtrNext == 2'd3);
                sdaNext = bitLevel(bitNext, effRead, effNack, effByte);
            end
            ST_STOP: begin
                case (qtrNext)
                    2'd0:    begin sclNext = 1'b1; sdaNext = 1'b1; end
                    2'd1:    begin sclNext = 1'b0; sdaNext = 1'b1; end
                    default: begin sclNext = 1'b0; sdaNext = 1'b0; end
                endcase
            end
            default: ;
        endcase
    end

    // Registered pins, bus ownership and the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclOe    <= 1'b0;
            sdaOe    <= 1'b0;
            busyReg  <= 1'b0;
            rspValid <= 1'b0;
            rspRdata <= 8'd0;
            rspNack  <= 1'b0;
        end else begin
            sclOe    <= sclNext;
            sdaOe    <= sdaNext;
            rspValid <= done;
            // Ownership starts with the SDA fall of START and ends after STOP Q3.
            if ((stateNext == ST_START) && (qtrNext == 2'd2)) begin
                busyReg <= 1'b1;
            end else if ((state == ST_STOP) && (stateNext == ST_IDLE)) begin
                busyReg <= 1'b0;
            end
            if (done) begin
                rspNack <= isRead ? nackBit : ackSample;
                if (isRead) begin
                    rspRdata <= rxShift;
                end
            end
        end
    end

    // Command latch and SDA sampling at the end of each bit's Q2.
    always_ff @(posedge clk) begin
        if (rst) begin
            doStop    <= 1'b0;
            isRead    <= 1'b0;
            nackBit   <= 1'b0;
            txByte    <= 8'd0;
            rxShift   <= 8'd0;
            ackSample <= 1'b0;
        end else begin
            if (accept) begin
                doStop  <= cmd_stop;
                isRead  <= cmd_read;
                nackBit <= cmd_nack;
                txByte  <= cmd_wdata;
            end
            if (sampleNow) begin
                if (bitIdx == 4'd8) begin
                    ackSample <= sda_in;
                end else begin
                    rxShift <= {rxShift[6:0], sda_in};
                end
            end
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = rspValid;
    assign rsp_rdata = rspRdata;
    assign rsp_nack  = rspNack;
    assign busy      = busyReg;
    assign scl_oe    = sclOe;
    assign sda_oe    = sdaOe;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: open-drain bus with pull-ups, a bus-functional
// register slave at address 0x3C, and a response scoreboard.
module tb_i2c_byte_master;

    localparam int QTR_DIV = 4;
    localparam int PH      = 4 * QTR_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_start = 1'b0;
    logic       cmd_stop = 1'b0;
    logic       cmd_read = 1'b0;
    logic       cmd_nack = 1'b0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       cmd_ready, rsp_valid, rsp_nack, busy, scl_oe, sda_oe;
    logic [7:0] rsp_rdata;

    logic slvSclHold = 1'b0;
    logic slvSdaLow  = 1'b0;
    wire  sclLine = ~scl_oe & ~slvSclHold;
    wire  sdaLine = ~sda_oe & ~slvSdaLow;

    int nChecks = 0;
    int nErrors = 0;
    int cyc = 0;
    int stretchFrom = -100;
    logic busModel = 1'b0;

    // Expected response: {chkRd, nack, rdata[7:0], latency[15:0]}.
    logic [25:0] expQ[$];
    int          accQ[$];
    logic [25:0] monE;
    int          monA;

    i2c_byte_master #(.QTR_DIV(QTR_DIV)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_read(cmd_read),
        .cmd_nack(cmd_nack), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .busy(busy),
        .scl_in(sclLine), .sda_in(sdaLine),
        .scl_oe(scl_oe), .sda_oe(sda_oe)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- bus-functional slave ----------------
    logic [7:0] slvRegs [0:255];
    logic [7:0] regPtr = 8'd0;
    logic [7:0] shiftIn = 8'd0;
    logic [7:0] slvTx = 8'd0;
    logic [7:0] lastRxByte = 8'd0;
    logic [3:0] bitCnt = 4'd0;
    logic [2:0] sState = 3'd0;   // 0 idle, 1 addr, 2 reg ptr, 3 write data, 4 read, 5 ignore
    logic [2:0] nextS = 3'd0;
    logic       masterAck = 1'b0;
    logic       ackAll = 1'b0;
    logic       prevScl = 1'b1;
    logic       prevSda = 1'b1;
    int         stopCount = 0;

    initial begin
        for (int i = 0; i < 256; i++) slvRegs[i] = 8'h00;
        slvRegs[4] = 8'hC3;
    end

    // Slave reacts to line edges seen between consecutive clk samples.
    always @(posedge clk) begin
        prevScl <= sclLine;
        prevSda <= sdaLine;
        if (prevScl && sclLine && prevSda && !sdaLine) begin
            sState    <= 3'd1;
            bitCnt    <= 4'd0;
            slvSdaLow <= 1'b0;
        end else if (prevScl && sclLine && !prevSda && sdaLine) begin
            sState    <= 3'd0;
            slvSdaLow <= 1'b0;
            stopCount <= stopCount + 1;
        end else if (sState != 3'd0) begin
            if (!prevScl && sclLine) begin
                if (bitCnt < 4'd8) begin
                    shiftIn <= {shiftIn[6:0], sdaLine};
                    bitCnt  <= bitCnt + 4'd1;
                end else if (bitCnt == 4'd8) begin
                    masterAck <= sdaLine;
                    bitCnt    <= 4'd9;
                end
            end else if (prevScl && !sclLine) begin
                if (bitCnt == 4'd8) begin
                    lastRxByte <= shiftIn;
                    case (sState)
                        3'd1: begin
                            if ((shiftIn[7:1] == 7'h3C) || ackAll) begin
                                slvSdaLow <= 1'b1;
                                nextS     <= shiftIn[0] ? 3'd4 : 3'd2;
                            end else begin
                                nextS <= 3'd5;
                            end
                        end
                        3'd2: begin regPtr <= shiftIn; slvSdaLow <= 1'b1; nextS <= 3'd3; end
                        3'd3: begin
                            slvRegs[regPtr] <= shiftIn;
                            regPtr    <= regPtr + 8'd1;
                            slvSdaLow <= 1'b1;
                            nextS     <= 3'd3;
                        end
                        3'd4: begin slvSdaLow <= 1'b0; nextS <= 3'd4; end
                        default: nextS <= 3'd5;
                    endcase
                end else if (bitCnt == 4'd9) begin
                    bitCnt    <= 4'd0;
                    slvSdaLow <= 1'b0;
                    if (nextS == 3'd4) begin
                        if ((sState == 3'd4) && masterAck) begin
                            sState <= 3'd5;
                        end else begin
                            sState    <= 3'd4;
                            slvTx     <= slvRegs[regPtr];
                            slvSdaLow <= ~slvRegs[regPtr][7];
                        end
                    end else begin
                        sState <= nextS;
                    end
                end else if ((sState == 3'd4) && (bitCnt >= 4'd1) && (bitCnt <= 4'd7)) begin
                    slvSdaLow <= ~slvTx[3'd7 - bitCnt[2:0]];
                end
            end
        end
    end

    // Slave clock stretch window, placed by the stimulus in absolute cycles.
    always @(negedge clk) begin
        if (cyc == stretchFrom) slvSclHold <= 1'b1;
        if (cyc == stretchFrom + 51) slvSclHold <= 1'b0;
    end

    // Scoreboard: compare each response with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (expQ.size() == 0) begin
                checkVal("spuriousRsp", rsp_valid, 1'b0);
            end else begin
                monE = expQ.pop_front();
                monA = accQ.pop_front();
                checkVal("latency", cyc - monA, {16'd0, monE[15:0]});
                checkVal("rspNack", rsp_nack, monE[24]);
                if (monE[25]) checkVal("rspRdata", rsp_rdata, monE[23:16]);
                checkVal("readyWithRsp", cmd_ready, 1'b1);
            end
        end
    end

    // Driver: offer one command, record the expected response on acceptance.
    task automatic sendCmd(input logic st, input logic sp, input logic rd, input logic nk,
                           input logic [7:0] wd, input logic expNack, input logic chkRd,
                           input logic [7:0] expRd, input int extra, output int accAt);
        int lat;
        @(negedge clk);
        cmd_start = st; cmd_stop = sp; cmd_read = rd; cmd_nack = nk; cmd_wdata = wd;
        cmd_valid = 1'b1;
        for (int i = 0; i < 2000 && !cmd_ready; i++) @(negedge clk);
        accAt = cyc;
        if (!cmd_ready) begin
            checkVal("cmdReadyTimeout", cmd_ready, 1'b1);
        end else begin
            lat = PH * (9 + ((st || !busModel) ? 1 : 0) + (sp ? 1 : 0)) + 1 + extra;
            expQ.push_back({chkRd, expNack, expRd, 16'(lat)});
            accQ.push_back(accAt);
            busModel = !sp;
            @(posedge clk);
        end
        #1 cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 3000 && expQ.size() != 0; i++) @(posedge clk);
        checkVal("rspTimeout", expQ.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int sBefore;
        // Reset state.
        repeat (3) @(negedge clk);
        checkVal("rstScl", scl_oe, 1'b0);
        checkVal("rstSda", sda_oe, 1'b0);
        checkVal("rstReady", cmd_ready, 1'b0);
        checkVal("rstRspValid", rsp_valid, 1'b0);
        checkVal("rstRdata", rsp_rdata, 8'h00);
        checkVal("rstNack", rsp_nack, 1'b0);
        checkVal("rstBusy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkVal("readyAfterRst", cmd_ready, 1'b1);

        // Single write 0x5A with START, no STOP; slave acks anything here.
        ackAll = 1'b1;
        sendCmd(1, 0, 0, 0, 8'h5A, 1'b0, 1'b0, 8'h00, 0, acc);
        waitIdle();
        checkVal("bits5A", lastRxByte, 8'h5A);
        checkVal("busyHeld", busy, 1'b1);
        checkVal("sclHeld", scl_oe, 1'b1);
        ackAll = 1'b0;

        // Register write: reg 2 = 0xA5 (repeated START since the bus is owned).
        sendCmd(1, 0, 0, 0, 8'h78, 1'b0, 1'b0, 8'h00, 0, acc);
        sendCmd(0, 0, 0, 0, 8'h02, 1'b0, 1'b0, 8'h00, 0, acc);
        sendCmd(0, 1, 0, 0, 8'hA5, 1'b0, 1'b0, 8'h00, 0, acc);
        waitIdle();
        checkVal("slvReg2", slvRegs[2], 8'hA5);
        checkVal("busyAfterWr", busy, 1'b0);
        checkVal("sclRelWr", scl_oe, 1'b0);
        checkVal("sdaRelWr", sda_oe, 1'b0);

        // Register read with repeated START.
        sBefore = stopCount;
        sendCmd(1, 0, 0, 0, 8'h78, 1'b0, 1'b0, 8'h00, 0, acc);
        sendCmd(0, 0, 0, 0, 8'h04, 1'b0, 1'b0, 8'h00, 0, acc);
        sendCmd(1, 0, 0, 0, 8'h79, 1'b0, 1'b0, 8'h00, 0, acc);
        sendCmd(0, 1, 1, 1, 8'h00, 1'b1, 1'b1, 8'hC3, 0, acc);
        waitIdle();
        checkVal("stopAfterRd", stopCount, sBefore + 1);
        checkVal("busyAfterRd", busy, 1'b0);

        // Absent address 0x55: NACK, STOP still issued.
        sBefore = stopCount;
        sendCmd(1, 1, 0, 0, 8'hAA, 1'b1, 1'b0, 8'h00, 0, acc);
        waitIdle();
        checkVal("stopAfterNack", stopCount, sBefore + 1);
        checkVal("busyAfterNack", busy, 1'b0);
        checkVal("sclRelNack", scl_oe, 1'b0);
        checkVal("sdaRelNack", sda_oe, 1'b0);

        // Clock stretch of 50 cycles in bit 3 Q1.
        sendCmd(1, 0, 0, 0, 8'h78, 1'b0, 1'b0, 8'h00, 50, acc);
        stretchFrom = acc + 1 + PH + 3 * PH + QTR_DIV - 1;
        waitIdle();
        checkVal("bitsStretch", lastRxByte, 8'h78);
        sendCmd(0, 1, 0, 0, 8'h07, 1'b0, 1'b0, 8'h00, 0, acc);
        waitIdle();
        checkVal("busyAfterStretch", busy, 1'b0);

        // Reset in the middle of bit 5 (Q1, data bit 0 drives SDA low).
        sendCmd(1, 1, 0, 0, 8'h78, 1'b0, 1'b0, 8'h00, 0, acc);
        while (cyc < acc + 1 + PH + 5 * PH + QTR_DIV + 1) @(negedge clk);
        checkVal("sdaBit5", sda_oe, 1'b1);
        checkVal("sclBit5", scl_oe, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        expQ.delete();
        accQ.delete();
        busModel = 1'b0;
        checkVal("midRstScl", scl_oe, 1'b0);
        checkVal("midRstSda", sda_oe, 1'b0);
        checkVal("midRstBusy", busy, 1'b0);
        checkVal("midRstReady", cmd_ready, 1'b0);
        checkVal("midRstRdata", rsp_rdata, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        checkVal("readyAfterMidRst", cmd_ready, 1'b1);

        // Bus usable again after the aborted transfer.
        sendCmd(1, 1, 0, 0, 8'hAA, 1'b1, 1'b0, 8'h00, 0, acc);
        waitIdle();
        checkVal("busyFinal", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
